// File: rtl/io_port_unit.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_unit
//  Purpose  : Board I/O responder for the control core. Latches OUTLED values
//             onto 16 LEDs and OUTSS values into a 32-bit register scanned
//             across 8 hex digits. Synchronizes and debounces 16 switches for
//             INSW reads and flags debounced changes since the last read.
//  Revision : 1.0  initial release
// ============================================================================
module io_port_unit #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  controlHI,
  input  logic [31:0] data_in,
  input  logic        should_read_from_input_instead_of_memory,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic [7:0]  anodes,
  output logic [7:0]  segments,
  output logic [31:0] input_value,
  output logic        switch_changed
);

  localparam int c_ref_w = $clog2(REFRESH_DIV);
  localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_ref_w-1:0] c_ref_last = c_ref_w'(REFRESH_DIV - 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_hi_outled = 2'd1;
  localparam logic [1:0] c_hi_outss  = 2'd2;

  logic [31:0]        r_display;
  logic [2:0]         r_index;
  logic [c_ref_w-1:0] r_refresh;
  logic [15:0]        r_sync1;
  logic [15:0]        r_sync2;
  logic [15:0]        r_cand;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic [15:0]        r_debounced;
  logic [3:0]         w_nibble;
  logic [6:0]         w_seg7;

  // Latch core output writes: OUTLED to the LEDs, OUTSS to the display register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leds      <= 16'h0000;
      r_display <= 32'h0000_0000;
    end else if (controlHI == c_hi_outled) begin
      leds <= data_in[15:0];
    end else if (controlHI == c_hi_outss) begin
      r_display <= data_in;
    end
  end

  // Digit scan: hold each digit REFRESH_DIV cycles, then step to the next one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_index   <= 3'd0;
    end else if (r_refresh == c_ref_last) begin
      r_refresh <= '0;
      r_index   <= r_index + 3'd1;
    end else begin
      r_refresh <= r_refresh + c_ref_w'(1);
    end
  end

  // Decode the selected nibble of the display register to active-low segments
  always_comb begin
    w_nibble = r_display[{r_index, 2'b00} +: 4];
    w_seg7   = 7'h7F;
    case (w_nibble)
      4'h0: w_seg7 = 7'h40;
      4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;
      4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;
      4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;
      4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;
      4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = 7'h08;
      4'hB: w_seg7 = 7'h03;
      4'hC: w_seg7 = 7'h46;
      4'hD: w_seg7 = 7'h21;
      4'hE: w_seg7 = 7'h06;
      4'hF: w_seg7 = 7'h0E;
      default: w_seg7 = 7'h7F;
    endcase
    anodes   = ~(8'b0000_0001 << r_index);
    segments = {1'b1, w_seg7};
  end

  // Two-flop synchronizer for the asynchronous switch levels
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 16'h0000;
      r_sync2 <= 16'h0000;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: any change restarts the window; a full stable window is accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cand      <= 16'h0000;
      r_deb_cnt   <= '0;
      r_debounced <= 16'h0000;
    end else if (r_sync2 != r_cand) begin
      r_cand    <= r_sync2;
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == c_deb_last) begin
      r_debounced <= r_cand;
    end else begin
      r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
    end
  end

  // Sticky change flag; a new change outranks a same-cycle read so none is lost
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      switch_changed <= 1'b0;
    end else if ((r_sync2 == r_cand) && (r_deb_cnt == c_deb_last) &&
                 (r_cand != r_debounced)) begin
      switch_changed <= 1'b1;
    end else if (should_read_from_input_instead_of_memory) begin
      switch_changed <= 1'b0;
    end
  end

  assign input_value = {16'h0000, r_debounced};

endmodule
`default_nettype wire

// File: tb/tb_io_port_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port_unit
//  Purpose  : Self-checking bench for io_port_unit against a behavioural
//             model (cycle count for the scan, sample history for debounce).
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_port_unit;

  localparam int REFRESH = 4;
  localparam int DEB     = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  ctrl = 2'd0;
  logic [31:0] din = 32'h0;
  logic        strobe = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [15:0] leds;
  logic [7:0]  anodes;
  logic [7:0]  segments;
  logic [31:0] input_value;
  logic        switch_changed;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          m_t;
  logic [15:0] m_leds;
  logic [31:0] m_disp;
  logic [15:0] m_deb;
  logic        m_chg;
  logic [15:0] m_hist[$];
  logic [6:0]  c_hex[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  io_port_unit #(.REFRESH_DIV(REFRESH), .DEBOUNCE_CYCLES(DEB)) u_dut (
    .clock                                   (clock),
    .reset                                   (reset),
    .controlHI                               (ctrl),
    .data_in                                 (din),
    .should_read_from_input_instead_of_memory(strobe),
    .switches                                (sw),
    .leds                                    (leds),
    .anodes                                  (anodes),
    .segments                                (segments),
    .input_value                             (input_value),
    .switch_changed                          (switch_changed)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_leds = 16'h0;
    m_disp = 32'h0;
    m_deb  = 16'h0;
    m_chg  = 1'b0;
    m_hist.delete();
    // Synchronizer flops clear on reset, so earlier history reads as zero
    for (int i = 0; i < DEB + 2; i++) m_hist.push_back(16'h0);
  endtask

  // State after the next rising edge, given the inputs currently driven
  task automatic model_step();
    logic stable;
    m_t++;
    if (ctrl == 2'd1) m_leds = din[15:0];
    else if (ctrl == 2'd2) m_disp = din;
    m_hist.push_back(sw);
    if (m_hist.size() > DEB + 3) void'(m_hist.pop_front());
    // Accept a value once DEB+1 consecutive samples, two edges old, agree
    stable = 1'b1;
    for (int i = 1; i <= DEB; i++) if (m_hist[i] != m_hist[0]) stable = 1'b0;
    if (stable && (m_hist[0] != m_deb)) begin
      m_deb = m_hist[0];
      m_chg = 1'b1;
    end else if (strobe) begin
      m_chg = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int         idx;
    logic [3:0] nib;
    idx = (m_t / REFRESH) % 8;
    nib = 4'((m_disp >> (4 * idx)) & 32'hF);
    check_eq("leds", {16'h0, leds}, {16'h0, m_leds});
    check_eq("anodes", {24'h0, anodes}, {24'h0, ~(8'b1 << idx)});
    check_eq("segments", {24'h0, segments}, {24'h0, 1'b1, c_hex[nib]});
    check_eq("input_value", input_value, {16'h0, m_deb});
    check_eq("switch_changed", {31'h0, switch_changed}, {31'h0, m_chg});
  endtask

  task automatic cycle(input logic [1:0] c, input logic [31:0] d, input logic s,
                       input logic [15:0] w);
    @(negedge clock);
    check_outputs();
    ctrl = c; din = d; strobe = s; sw = w;
    model_step();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_leds"}, {16'h0, leds}, 32'h0);
    check_eq({tag, "_anodes"}, {24'h0, anodes}, 32'hFE);
    check_eq({tag, "_segments"}, {24'h0, segments}, 32'hC0);
    check_eq({tag, "_input_value"}, input_value, 32'h0);
    check_eq({tag, "_switch_changed"}, {31'h0, switch_changed}, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_values(tag);
    ctrl = 2'd0; strobe = 1'b0;
    reset = 1'b1;
    model_step();
  endtask

  initial begin
    model_reset();
    // Reset values while held and after release
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b1;
    model_step();

    // Display write and full scan including wrap
    cycle(2'd2, 32'h1234ABCD, 1'b0, 16'h0);
    for (int i = 0; i < 40; i++) cycle(2'd0, 32'h0, 1'b0, 16'h0);

    // LED write, then reserved code leaves everything alone
    cycle(2'd1, 32'hFFFF5A5A, 1'b0, 16'h0);
    cycle(2'd3, 32'h0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) cycle(2'd0, 32'h0, 1'b0, 16'h0);

    // Stable switch change accepted after the debounce window
    for (int i = 0; i < 12; i++) cycle(2'd0, 32'h0, 1'b0, 16'h00F0);
    cycle(2'd0, 32'h0, 1'b1, 16'h00F0);
    cycle(2'd0, 32'h0, 1'b0, 16'h00F0);

    // Short pulses never reach the debounced value
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) cycle(2'd0, 32'h0, 1'b0, 16'h00F1);
      for (int i = 0; i < 3; i++) cycle(2'd0, 32'h0, 1'b0, 16'h00F0);
    end

    // Read strobe on the accepting edge, then alone on the following edge
    for (int i = 0; i < 6; i++) cycle(2'd0, 32'h0, 1'b0, 16'h0003);
    cycle(2'd0, 32'h0, 1'b1, 16'h0003);
    cycle(2'd0, 32'h0, 1'b1, 16'h0003);
    for (int i = 0; i < 3; i++) cycle(2'd0, 32'h0, 1'b0, 16'h0003);

    // Randomized traffic with a mid-operation reset
    for (int i = 0; i < 600; i++) begin
      logic [15:0] nsw;
      nsw = sw;
      if ($urandom_range(0, 9) == 0) nsw = 16'($urandom);
      if (i == 300) do_reset("mid");
      cycle(2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0), nsw);
    end
    @(negedge clock);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
